// File: rtl/inst_mem_ws.sv
// Wait-state instruction memory: word array with programmable read latency,
// fetch stall request and run-time load port. Optional error flag: INST_MEM_ERR_EN.
module inst_mem_ws #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              stall_o,
  output logic              err_o,
  input  logic              load_we_i,
  input  logic [31:0]       load_addr_i,
  input  logic [DATA_W-1:0] load_data_i
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [31:0]           cap_addr;
  logic [31:0]           served_addr;
  logic                  have_data;
  logic [DATA_W-1:0]     inst_r;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic [DEPTH_LOG2-1:0] cap_word, load_word, served_word;
  logic [DATA_W-1:0]     rd_data;
  logic                  req_new;
  logic                  unused_bits;

  assign cap_word    = cap_addr[DEPTH_LOG2+1:2];
  assign load_word   = load_addr_i[DEPTH_LOG2+1:2];
  assign served_word = served_addr[DEPTH_LOG2+1:2];
  assign unused_bits = ^{load_addr_i[31:DEPTH_LOG2+2], load_addr_i[1:0]};

  assign req_new = ce_i && !(have_data && addr_i == served_addr && state == S_IDLE);
  assign stall_o = req_new;
  assign inst_o  = ce_i ? inst_r : '0;

  // A load landing on the word being completed this edge wins over the stale array value.
  assign rd_data = (load_we_i && load_word == cap_word) ? load_data_i : mem[cap_word];

  always_ff @(posedge clk) begin
    if (load_we_i) mem[load_word] <= load_data_i;
  end

`ifdef INST_MEM_ERR_EN
  logic err_r;
  logic cap_bad;
  assign cap_bad = (cap_addr[1:0] != 2'b0) || (cap_addr[31:DEPTH_LOG2+2] != '0);
  assign err_o   = ce_i && err_r;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cap_addr    <= '0;
      served_addr <= '0;
      have_data   <= 1'b0;
      inst_r      <= '0;
`ifdef INST_MEM_ERR_EN
      err_r       <= 1'b0;
`endif
    end else begin
      // Overwriting the served word invalidates the cached copy; a completion below may re-set it.
      if (load_we_i && load_word == served_word) have_data <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_new) begin
            cap_addr <= addr_i;
            cnt      <= WAIT_INIT;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!ce_i) begin
            state <= S_IDLE;
          end else if (addr_i != cap_addr) begin
            cap_addr <= addr_i;
            cnt      <= WAIT_INIT;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            served_addr <= cap_addr;
            have_data   <= 1'b1;
            state       <= S_IDLE;
`ifdef INST_MEM_ERR_EN
            err_r  <= cap_bad;
            inst_r <= cap_bad ? '0 : rd_data;
`else
            inst_r <= rd_data;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_ws.sv
// Self-checking bench for inst_mem_ws: directed test-plan steps followed by a
// randomized phase, all checked against a timestamp-based reference model.
module tb_inst_mem_ws;
  localparam int W     = 2;
  localparam int DEPTH = 1024;

  logic        clk = 0;
  logic        rst = 0;
  logic        ce_i = 0;
  logic [31:0] addr_i = 0;
  logic [31:0] inst_o;
  logic        stall_o;
  logic        err_o;
  logic        load_we_i = 0;
  logic [31:0] load_addr_i = 0;
  logic [31:0] load_data_i = 0;

  inst_mem_ws #(.DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_o),
    .stall_o(stall_o), .err_o(err_o), .load_we_i(load_we_i),
    .load_addr_i(load_addr_i), .load_data_i(load_data_i)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Reference model: a fetch is outstanding until an absolute due cycle.
  logic [31:0] m_mem [DEPTH];
  bit          m_pend, m_have, m_err;
  logic [31:0] m_paddr, m_served, m_inst;
  int          m_due;
  int          cyc = 0;
  logic        last_stall;
  logic [31:0] last_inst;

  function automatic int word(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || ((a >> 12) != 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit exp_stall();
    return ce_i && !(m_have && addr_i == m_served && !m_pend);
  endfunction

  task automatic model_edge();
    bit st;
    st = exp_stall();
    if (load_we_i) m_mem[word(load_addr_i)] = load_data_i;
    if (!rst) begin
      m_pend = 0; m_have = 0; m_err = 0; m_served = 0; m_inst = 0; m_paddr = 0;
    end else begin
      if (load_we_i && word(load_addr_i) == word(m_served)) m_have = 0;
      if (m_pend) begin
        if (!ce_i) m_pend = 0;
        else if (addr_i != m_paddr) begin
          m_paddr = addr_i; m_due = cyc + W + 1;
        end else if (cyc == m_due) begin
          m_pend = 0; m_have = 1; m_served = m_paddr;
`ifdef INST_MEM_ERR_EN
          m_err  = bad_addr(m_paddr);
          m_inst = m_err ? 32'h0 : m_mem[word(m_paddr)];
`else
          m_inst = m_mem[word(m_paddr)];
`endif
        end
      end else if (st) begin
        m_pend = 1; m_paddr = addr_i; m_due = cyc + W + 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("stall", {31'b0, stall_o}, {31'b0, exp_stall()});
    chk("inst", inst_o, ce_i ? m_inst : 32'h0);
    chk("err", {31'b0, err_o}, {31'b0, ce_i && m_err});
    last_stall = stall_o;
    last_inst  = inst_o;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we_i = 1; load_addr_i = a; load_data_i = d;
    step();
    load_we_i = 0;
  endtask

  // Holds addr until stall drops; returns number of stalled cycles (bounded).
  task automatic fetch(input logic [31:0] a, output int nst);
    ce_i = 1; addr_i = a; nst = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_stall) nst++;
      else break;
    end
  endtask

  int nst;

  initial begin
    m_pend = 0; m_have = 0; m_err = 0; m_served = 0; m_inst = 0; m_paddr = 0; m_due = 0;
    @(posedge clk); #1;
    step();
    ce_i = 1; addr_i = 0;
    step();
    rst = 1; ce_i = 0;

    load(32'h0, 32'h34011100);
    for (int i = 1; i < 16; i++) load(32'(i * 4), $urandom);

    fetch(32'h0, nst);
    chk("lat_first", nst, W + 2);
    chk("data_first", last_inst, 32'h34011100);

    fetch(32'h4, nst);
    chk("lat_seq4", nst, W + 2);
    chk("data_seq4", last_inst, m_mem[1]);
    fetch(32'h8, nst);
    chk("lat_seq8", nst, W + 2);
    fetch(32'h8, nst);
    chk("lat_repeat", nst, 0);

    ce_i = 1; addr_i = 32'h4;
    step(); step();
    fetch(32'h10, nst);
    chk("lat_restart", nst, W + 2);
    chk("data_restart", last_inst, m_mem[4]);

    fetch(32'h0, nst);
    load(32'h0, 32'hFFFFFFFF);
    fetch(32'h0, nst);
    chk("lat_reload", nst, W + 2);
    chk("data_reload", last_inst, 32'hFFFFFFFF);

    ce_i = 1; addr_i = 32'h8;
    step();
    rst = 0;
    step();
    rst = 1; ce_i = 0;
    step();
    ce_i = 1;
    step();

    fetch(32'h1000, nst);
    chk("lat_alias", nst, W + 2);
`ifdef INST_MEM_ERR_EN
    chk("data_alias", last_inst, 32'h0);
    chk("err_alias", {31'b0, err_o}, 32'h1);
`else
    chk("data_alias", last_inst, 32'hFFFFFFFF);
    chk("err_alias", {31'b0, err_o}, 32'h0);
`endif

    for (int i = 0; i < 800; i++) begin
      if (!last_stall || $urandom_range(9) == 0) begin
        addr_i = ($urandom_range(19) == 0) ? 32'h1000 + 32'($urandom_range(15)) * 4
                                           : 32'($urandom_range(15)) * 4;
        if ($urandom_range(29) == 0) addr_i = addr_i | 32'($urandom_range(1, 3));
      end
      ce_i = ($urandom_range(9) != 0);
      rst  = ($urandom_range(49) != 0);
      load_we_i   = ($urandom_range(7) == 0);
      load_addr_i = 32'($urandom_range(15)) * 4;
      load_data_i = $urandom;
      step();
    end
    load_we_i = 0; rst = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
